// File: rtl/pipe_field.sv
// rtl/pipe_field.sv - scrolling pipe-pair obstacles with LFSR gap heights and per-pixel column flags
// Positions advance on the falling edge of the frame strobe; pixel flags lag x/y by one clock.

module pipe_field_lfsr #(
   parameter logic [15:0] SEED    = 16'hACE1,
   parameter logic [15:0] MASK    = 16'hB400,
   parameter int          NUM_OUT = 2
) (
   input  logic                   clk,
   input  logic                   RESET,
   output logic [8*NUM_OUT-1:0]   rnd
);
   logic [15:0] value;

   always_ff @(posedge clk) begin
      if (RESET) begin
         value <= SEED;
      end else begin
         value <= {1'b0, value[15:1]} ^ (value[0] ? MASK : 16'h0000);
      end
   end

   // byte i is the low byte of the register rotated left by 3*i
   for (genvar g = 0; g < NUM_OUT; g++) begin : g_rot
      for (genvar k = 0; k < 8; k++) begin : g_bit
         assign rnd[8*g+k] = value[(k + 48 - 3*g) % 16];
      end
   end
endmodule

module pipe_field #(
   parameter int          NUM_PIPES = 2,
   parameter int          PIPE_W    = 52,
   parameter int          GAP_H     = 90,
   parameter int          SPACING   = 320,
   parameter int          INIT_X    = 650,
   parameter int          SPAWN_X   = 640,
   parameter int          WRAP_LIM  = 972,
   parameter int          Y_MIN     = 110,
   parameter int          Y_MAX     = 315,
   parameter int          GROUND_Y  = 425,
   parameter int          BIRD_X    = 120,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       RESET,
   input  logic       fresh,
   input  logic       game_status,
   input  logic [3:0] speed,
   input  logic [9:0] x,
   input  logic [8:0] y,
   output logic       score_pulse,
   output logic       is_column_up,
   output logic       is_column_down,
   output logic [9:0] pipe_x,
   output logic [8:0] pipe_y
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   fresh_d;
   logic   tick;
   logic   run_tick;

   logic [8*NUM_PIPES-1:0] rnd;
   logic [NUM_PIPES-1:0]   hit_h;
   logic [NUM_PIPES-1:0]   first_hit;
   logic [NUM_PIPES-1:0]   score_hit;
   logic [NUM_PIPES:0][9:0] x_chain;
   logic [NUM_PIPES:0][8:0] y_chain;
   logic [NUM_PIPES:0]      up_chain;
   logic [NUM_PIPES:0]      down_chain;

   assign tick     = fresh_d & ~fresh;
   assign run_tick = (state == ST_RUN) & tick;

   pipe_field_lfsr #(
      .SEED    (LFSR_SEED),
      .MASK    (16'hB400),
      .NUM_OUT (NUM_PIPES)
   ) u_lfsr (
      .clk   (clk),
      .RESET (RESET),
      .rnd   (rnd)
   );

   always_ff @(posedge clk) begin
      if (RESET) begin
         state   <= ST_IDLE;
         fresh_d <= 1'b0;
      end else begin
         state   <= state_nxt;
         fresh_d <= fresh;
      end
   end

   // HALT is terminal until reset so a crashed game keeps its final picture
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (game_status)  state_nxt = ST_RUN;
         ST_RUN:  if (!game_status) state_nxt = ST_HALT;
         default: state_nxt = state;
      endcase
   end

   assign x_chain[0]    = '0;
   assign y_chain[0]    = '0;
   assign up_chain[0]   = 1'b0;
   assign down_chain[0] = 1'b0;

   // isolate the lowest-index horizontal hit
   assign first_hit = hit_h & (-hit_h);

   for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
      logic [9:0]  px_q;
      logic [8:0]  py_q;
      logic        wrapped;
      logic [10:0] lead;
      logic [10:0] clip_end;
      logic [11:0] trail;
      logic [8:0]  y_sum;
      logic [8:0]  y_spawn;
      logic        col_up;
      logic        col_down;

      always_ff @(posedge clk) begin
         if (RESET) begin
            px_q <= 10'(INIT_X + g*SPACING);
            py_q <= (g % 2 == 0) ? 9'(Y_MAX) : 9'(Y_MIN + 35);
         end else if (run_tick) begin
            if (wrapped) begin
               px_q <= 10'(SPAWN_X);
               py_q <= y_spawn;
            end else begin
               px_q <= px_q - {6'd0, speed};
            end
         end
      end

      // x values at or past WRAP_LIM are negative positions that wrapped modulo 1024
      assign wrapped  = px_q >= 10'(WRAP_LIM);
      assign lead     = {1'b0, px_q} + 11'(PIPE_W);
      assign clip_end = lead - 11'd1024;
      assign trail    = {2'b00, px_q} - {8'd0, speed} + 12'(PIPE_W);

      assign y_sum   = 9'(Y_MIN) + {1'b0, rnd[8*g +: 8]};
      assign y_spawn = (y_sum > 9'(Y_MAX)) ? 9'(Y_MAX) : y_sum;

      assign score_hit[g] = !wrapped && (lead > 11'(BIRD_X)) &&
                            ($signed(trail) <= $signed(12'(BIRD_X)));

      assign hit_h[g] = wrapped ? ({1'b0, x} < clip_end)
                                : ((x >= px_q) && ({1'b0, x} < lead));
      assign col_up   = (y >= py_q) && (y < 9'(GROUND_Y));
      assign col_down = y <= (py_q - 9'(GAP_H));

      assign x_chain[g+1]    = x_chain[g] | ({10{first_hit[g]}} & px_q);
      assign y_chain[g+1]    = y_chain[g] | ({9{first_hit[g]}} & py_q);
      assign up_chain[g+1]   = up_chain[g] | (first_hit[g] & col_up);
      assign down_chain[g+1] = down_chain[g] | (first_hit[g] & col_down);
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         score_pulse    <= 1'b0;
         is_column_up   <= 1'b0;
         is_column_down <= 1'b0;
         pipe_x         <= '0;
         pipe_y         <= '0;
      end else begin
         score_pulse    <= run_tick & (|score_hit);
         is_column_up   <= up_chain[NUM_PIPES];
         is_column_down <= down_chain[NUM_PIPES];
         if (|hit_h) begin
            pipe_x <= x_chain[NUM_PIPES];
            pipe_y <= y_chain[NUM_PIPES];
         end
      end
   end
endmodule

// File: tb/tb_pipe_field.sv
// tb/tb_pipe_field.sv - randomized scoreboard bench for pipe_field against a behavioural model
// Stimulus pushes expected outputs; an independent monitor pops and compares one clock later.

module tb_pipe_field;
   localparam int NP = 2;

   logic       clk = 1'b0;
   logic       RESET;
   logic       fresh;
   logic       game_status;
   logic [3:0] speed;
   logic [9:0] x;
   logic [8:0] y;
   logic       score_pulse;
   logic       is_column_up;
   logic       is_column_down;
   logic [9:0] pipe_x;
   logic [8:0] pipe_y;

   always #5 clk = ~clk;

   pipe_field dut (
      .clk            (clk),
      .RESET          (RESET),
      .fresh          (fresh),
      .game_status    (game_status),
      .speed          (speed),
      .x              (x),
      .y              (y),
      .score_pulse    (score_pulse),
      .is_column_up   (is_column_up),
      .is_column_down (is_column_down),
      .pipe_x         (pipe_x),
      .pipe_y         (pipe_y)
   );

   typedef struct packed {
      logic       sp;
      logic       up;
      logic       dn;
      logic [9:0] px;
      logic [8:0] py;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // model state: positions as plain integers, game mode 0 idle / 1 run / 2 halt
   int mpx[NP];
   int mpy[NP];
   int mstate, mlfsr, mfd, mox, moy;
   int cyc = 0;

   function automatic void model_reset();
      for (int i = 0; i < NP; i++) begin
         mpx[i] = (650 + i*320) % 1024;
         mpy[i] = (i % 2 == 0) ? 315 : 145;
      end
      mstate = 0;
      mlfsr  = 'hACE1;
      mfd    = 0;
      mox    = 0;
      moy    = 0;
   endfunction

   function automatic int rand_gap(int lf, int i);
      int s, r, ny;
      s  = 3*i;
      r  = ((lf << s) | (lf >> (16 - s))) & 'hFFFF;
      ny = 110 + (r & 255);
      return (ny > 315) ? 315 : ny;
   endfunction

   task automatic step(input bit rst, input bit fr, input bit gs, input int spd,
                       input int xx, input int yy);
      exp_t e;
      bit   tick, found, h;
      int   end_x;
      @(negedge clk);
      RESET       = rst;
      fresh       = fr;
      game_status = gs;
      speed       = spd[3:0];
      x           = xx[9:0];
      y           = yy[8:0];
      cyc++;
      e = '0;
      if (rst) begin
         model_reset();
      end else begin
         tick  = (mfd == 1) && !fr;
         found = 0;
         e.up  = 0;
         e.dn  = 0;
         for (int i = 0; i < NP; i++) begin
            end_x = mpx[i] + 52;
            if (mpx[i] < 972) h = (xx >= mpx[i]) && (xx < end_x);
            else              h = xx < end_x - 1024;
            if (h && !found) begin
               found = 1;
               e.up  = (yy >= mpy[i]) && (yy < 425);
               e.dn  = yy <= mpy[i] - 90;
               mox   = mpx[i];
               moy   = mpy[i];
            end
         end
         e.px = mox[9:0];
         e.py = moy[8:0];
         e.sp = 0;
         if (mstate == 1 && tick) begin
            for (int i = 0; i < NP; i++) begin
               if (mpx[i] < 972 && mpx[i] + 52 > 120 && mpx[i] - spd + 52 <= 120) e.sp = 1;
            end
            for (int i = 0; i < NP; i++) begin
               if (mpx[i] >= 972) begin
                  mpx[i] = 640;
                  mpy[i] = rand_gap(mlfsr, i);
               end else begin
                  mpx[i] = (mpx[i] - spd + 1024) % 1024;
               end
            end
         end
         if (mstate == 0 && gs)       mstate = 1;
         else if (mstate == 1 && !gs) mstate = 2;
         mlfsr = (mlfsr >> 1) ^ (((mlfsr & 1) != 0) ? 'hB400 : 0);
         mfd   = fr;
      end
      exp_q.push_back(e);
   endtask

   task automatic pick_pixel(output int xx, output int yy);
      int k;
      k  = $urandom_range(0, NP-1);
      xx = (mpx[k] + $urandom_range(0, 57) + 1021) % 1024;
      case ($urandom_range(0, 3))
         0: begin xx = $urandom_range(0, 1023); yy = $urandom_range(0, 511); end
         1: yy = (mpy[k] + $urandom_range(0, 20) + 502) % 512;
         2: yy = mpy[k] - 93 + $urandom_range(0, 6);
         default: yy = $urandom_range(400, 450);
      endcase
   endtask

   function automatic bit frame_phase();
      return (cyc % 4) < 2;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({score_pulse, is_column_up, is_column_down, pipe_x, pipe_y} !== e) begin
               miscompares++;
               $display("FAIL vec%0d got sp=%b up=%b dn=%b px=%0d py=%0d want sp=%b up=%b dn=%b px=%0d py=%0d",
                        vectors, score_pulse, is_column_up, is_column_down, pipe_x, pipe_y,
                        e.sp, e.up, e.dn, e.px, e.py);
            end
         end
      end
   end

   initial begin : stimulus
      int  xx, yy, spd, guard;
      bit  rst, fr, gs;
      RESET = 1'b1; fresh = 1'b0; game_status = 1'b0; speed = '0; x = '0; y = '0;
      model_reset();

      // reset, then idle: pipes must hold at their initial slots
      for (int i = 0; i < 3; i++) begin pick_pixel(xx, yy); step(1, 0, 0, 0, xx, yy); end
      for (int i = 0; i < 12; i++) begin pick_pixel(xx, yy); step(0, frame_phase(), 0, 4, xx, yy); end

      // run at speed 4 for ten frames, then stop the game and confirm nothing moves
      for (int i = 0; i < 42; i++) begin pick_pixel(xx, yy); step(0, frame_phase(), 1, 4, xx, yy); end
      for (int i = 0; i < 24; i++) begin pick_pixel(xx, yy); step(0, frame_phase(), 0, 4, xx, yy); end

      // bring pipe 0 to x=200 and probe the up / down / gap rows
      step(1, 0, 0, 0, 0, 0);
      guard = 0;
      while (mpx[0] != 200 && guard < 2000) begin
         pick_pixel(xx, yy);
         step(0, frame_phase(), 1, 10, xx, yy);
         guard++;
      end
      if (mpx[0] != 200) begin
         miscompares++;
         $display("FAIL setup_x200 got x=%0d want 200", mpx[0]);
      end
      step(0, frame_phase(), 1, 0, 210, 320);
      step(0, frame_phase(), 1, 0, 210, 225);
      step(0, frame_phase(), 1, 0, 210, 300);
      step(0, frame_phase(), 1, 0, 251, 400);
      step(0, frame_phase(), 1, 0, 252, 400);

      // long random play with occasional resets, some landing on a RUN tick
      for (int seg = 0; seg < 5; seg++) begin
         step(1, 0, 0, 0, 0, 0);
         for (int i = 0; i < 3500; i++) begin
            fr  = $urandom_range(0, 1);
            gs  = ($urandom_range(0, 99) != 0);
            spd = $urandom_range(0, 15);
            rst = (mstate == 1 && mfd == 1 && !fr && $urandom_range(0, 149) == 0) ||
                  (mstate == 2 && $urandom_range(0, 49) == 0) ||
                  ($urandom_range(0, 999) == 0);
            pick_pixel(xx, yy);
            step(rst, fr, gs, spd, xx, yy);
         end
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
